featuremap_accum: RTL and testbench

- Parametrised cross-channel feature-map accumulator for the conv stage.
- Receives NUM_CH per-channel partial-sum streams from the conv2d5x5 instances and aligns them through per-channel skid FIFOs.
- Sums one word from each channel, adds a fixed-point bias, saturates, optionally applies ReLU, and emits one feature-map pixel per beat under a valid/ready handshake.
- Replaces hand-wired per-instance output tie-offs with a single arbitrated output.

---
 rtl/featuremap_accum.sv | 165 ++++++++++++++++
 tb/tb_featuremap_accum.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/featuremap_accum.sv
// Cross-channel feature-map accumulator: per-channel alignment FIFOs, two-stage sum/bias/saturate
// pipeline. Define FEATUREMAP_ACCUM_RELU_EN to clamp negative results to zero.
module featuremap_accum #(
    parameter int unsigned                  DATA_WIDTH = 24,
    parameter int unsigned                  NUM_CH     = 6,
    parameter int unsigned                  FIFO_DEPTH = 4,
    parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
    input  logic [NUM_CH-1:0]            ch_valid_in,
    output logic [NUM_CH-1:0]            ch_ready_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         sat_flag
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = DATA_WIDTH + $clog2(NUM_CH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q [NUM_CH];
    logic [PW-1:0]         rd_ptr_q [NUM_CH];
    logic [CW-1:0]         cnt_q    [NUM_CH];

    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic                  pop;

    logic                  s1_valid_q;
    logic signed [SW-1:0]  s1_sum_q;
    logic                  s1_ready;
    logic                  s2_ready;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sat_q;

    logic [DATA_WIDTH-1:0] head;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  biased;
    logic [DATA_WIDTH-1:0] sat_val;
    logic [DATA_WIDTH-1:0] res;
    logic                  sat_hit;

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]  = (cnt_q[i] == FULL_CNT);
            empty[i] = (cnt_q[i] == '0);
            push[i]  = ch_valid_in[i] && !full[i];
        end
    end

    assign ch_ready_out = ~full;

    // A stage advances when it is empty or its successor advances.
    assign s2_ready = !valid_q || ready_in;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign pop      = !(|empty) && s1_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= ch_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
                if (push[i] && !pop) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!push[i] && pop) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        head = '0;
        sum  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            head = mem_q[i][rd_ptr_q[i]];
            sum  = sum + {{(SW - DATA_WIDTH){head[DATA_WIDTH-1]}}, head};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= pop;
            if (pop) begin
                s1_sum_q <= sum;
            end
        end
    end

    // SW leaves headroom for the full channel sum plus bias, so the add cannot wrap.
    always_comb begin
        biased  = s1_sum_q + {{(SW - DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};
        sat_hit = 1'b0;
        sat_val = biased[DATA_WIDTH-1:0];
        if (biased > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (biased < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

`ifdef FEATUREMAP_ACCUM_RELU_EN
    assign res = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    assign res = sat_val;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else if (s2_ready) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q <= res;
                if (sat_hit) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_featuremap_accum.sv
// Self-checking bench for featuremap_accum: directed scenarios plus a randomized phase scored
// against a queue-based reference model of the channel alignment and pixel arithmetic.
module tb_featuremap_accum;
    localparam int DW     = 24;
    localparam int NCH    = 6;
    localparam int DEPTH  = 4;
    localparam int BIAS_I = 1;
    localparam logic signed [DW-1:0] TB_BIAS = DW'(BIAS_I);
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));
`ifdef FEATUREMAP_ACCUM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH*DW-1:0]     ch_data_in;
    logic [NCH-1:0]        ch_valid_in;
    logic [NCH-1:0]        ch_ready_out;
    logic [DW-1:0]         data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  sat_flag;

    int errors = 0;
    int checks = 0;
    int beats  = 0;

    // Reference model state: accepted words per channel, then completed pixels awaiting output.
    logic [DW-1:0] chq [NCH][$];
    logic [DW-1:0] exp_q[$];
    bit            exp_sat_q[$];
    bit            sat_model;

    featuremap_accum #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .BIAS       (TB_BIAS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_data_in   (ch_data_in),
        .ch_valid_in  (ch_valid_in),
        .ch_ready_out (ch_ready_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_pixel(input longint s, output logic [DW-1:0] v, output bit sat);
        longint t;
        t   = s + longint'(TB_BIAS);
        sat = 1'b0;
        if (t > MAXV) begin
            t   = MAXV;
            sat = 1'b1;
        end else if (t < MINV) begin
            t   = MINV;
            sat = 1'b1;
        end
        if (RELU && t < 0) t = 0;
        v = t[DW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic [DW-1:0] val);
        for (int i = 0; i < NCH; i++) ch_data_in[i*DW +: DW] = val;
        ch_valid_in = '1;
    endtask

    task automatic randomize_inputs();
        logic [DW-1:0] w;
        int v;
        for (int i = 0; i < NCH; i++) begin
            ch_valid_in[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                w = DW'($urandom);
            end else begin
                v = int'($urandom_range(0, 2000)) - 1000;
                w = DW'(v);
            end
            ch_data_in[i*DW +: DW] = w;
        end
        ready_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_sat"}, 32'(sat_flag), 32'd0);
        check({tag, "_ready"}, 32'(ch_ready_out), 32'h3F);
    endtask

    // Scoreboard: inputs are stable here, so what is seen now is what the next edge consumes.
    always @(negedge clk) begin : monitor
        int n;
        longint s;
        logic [DW-1:0] w;
        logic [DW-1:0] pv;
        bit ps;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) chq[i].delete();
            exp_q.delete();
            exp_sat_q.delete();
            sat_model = 1'b0;
        end else begin
            if (valid_out) begin
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("out_data", 32'(data_out), 32'(exp_q[0]));
                    check("out_sat", 32'(sat_flag), 32'(sat_model | exp_sat_q[0]));
                    if (ready_in) begin
                        sat_model = sat_model | exp_sat_q[0];
                        void'(exp_q.pop_front());
                        void'(exp_sat_q.pop_front());
                        beats++;
                    end
                end
            end else begin
                check("idle_sat", 32'(sat_flag), 32'(sat_model));
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid_in[i] && ch_ready_out[i]) chq[i].push_back(ch_data_in[i*DW +: DW]);
            end
            n = chq[0].size();
            for (int i = 1; i < NCH; i++) if (chq[i].size() < n) n = chq[i].size();
            repeat (n) begin
                s = 0;
                for (int i = 0; i < NCH; i++) begin
                    w = chq[i].pop_front();
                    s = s + longint'($signed(w));
                end
                model_pixel(s, pv, ps);
                exp_q.push_back(pv);
                exp_sat_q.push_back(ps);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc [NCH];
        int nxt [NCH];
        int b0;
        int waited;

        // Reset with random inputs.
        rst = 1'b0;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        ch_valid_in = '0;
        check_reset_state("reset");
        rst      = 1'b1;
        ready_in = 1'b1;
        check("reset_release_ready", 32'(ch_ready_out), 32'h3F);

        // Aligned arrival of 1..6.
        for (int i = 0; i < NCH; i++) ch_data_in[i*DW +: DW] = DW'(i + 1);
        ch_valid_in = '1;
        step();
        ch_valid_in = '0;
        check("aligned_lat0", 32'(valid_out), 32'd0);
        step();
        check("aligned_lat1", 32'(valid_out), 32'd0);
        step();
        check("aligned_valid", 32'(valid_out), 32'd1);
        check("aligned_data", 32'(data_out), 32'(DW'(21 + BIAS_I)));
        step();
        check("aligned_one_beat", 32'(valid_out), 32'd0);

        // Skewed arrival: channel 5 three cycles late.
        for (int i = 0; i < NCH; i++) ch_data_in[i*DW +: DW] = DW'(10);
        ch_valid_in = 6'h1F;
        step();
        ch_valid_in = '0;
        check("skew_c0", 32'(valid_out), 32'd0);
        step();
        check("skew_c1", 32'(valid_out), 32'd0);
        step();
        check("skew_c2", 32'(valid_out), 32'd0);
        ch_valid_in = 6'h20;
        step();
        ch_valid_in = '0;
        check("skew_c3", 32'(valid_out), 32'd0);
        step();
        check("skew_c4", 32'(valid_out), 32'd0);
        step();
        check("skew_valid", 32'(valid_out), 32'd1);
        check("skew_data", 32'(data_out), 32'(DW'(60 + BIAS_I)));
        step();
        check("skew_one_beat", 32'(valid_out), 32'd0);

        // Positive and negative saturation.
        drive_all(24'h7FFFFF);
        step();
        ch_valid_in = '0;
        step();
        step();
        check("satpos_valid", 32'(valid_out), 32'd1);
        check("satpos_data", 32'(data_out), 32'h7FFFFF);
        check("satpos_flag", 32'(sat_flag), 32'd1);
        drive_all(24'h800000);
        step();
        ch_valid_in = '0;
        step();
        step();
        check("satneg_data", 32'(data_out), RELU ? 32'd0 : 32'h800000);
        check("satneg_flag", 32'(sat_flag), 32'd1);

        // Negative sum: 6 * -1 + 1 = -5.
        drive_all(24'hFFFFFF);
        step();
        ch_valid_in = '0;
        step();
        step();
        check("neg_data", 32'(data_out), RELU ? 32'd0 : 32'hFFFFFB);
        check("neg_sat_sticky", 32'(sat_flag), 32'd1);
        step();

        // Backpressure: every channel offers incrementing words while the output is stalled.
        ready_in = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            acc[i] = 0;
            nxt[i] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NCH; i++) ch_data_in[i*DW +: DW] = DW'(nxt[i] * 100 + i + 1);
            ch_valid_in = '1;
            for (int i = 0; i < NCH; i++) begin
                if (ch_ready_out[i]) begin
                    acc[i]++;
                    nxt[i]++;
                end
            end
            step();
        end
        ch_valid_in = '0;
        for (int i = 0; i < NCH; i++) check("bp_accepted", 32'(acc[i]), 32'd6);
        check("bp_ready_low", 32'(ch_ready_out), 32'd0);
        check("bp_hold_valid", 32'(valid_out), 32'd1);
        check("bp_hold_data", 32'(data_out), 32'(DW'(21 + BIAS_I)));
        b0       = beats;
        ready_in = 1'b1;
        waited   = 0;
        while ((beats - b0) < 6 && waited < 30) begin
            step();
            waited++;
        end
        step();
        step();
        check("bp_drain_beats", 32'(beats - b0), 32'd6);
        check("bp_ready_back", 32'(ch_ready_out), 32'h3F);

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1'b0;
                randomize_inputs();
                step();
                ch_valid_in = '0;
                check_reset_state("midreset");
                rst = 1'b1;
            end
            randomize_inputs();
            step();
        end
        ch_valid_in = '0;
        ready_in    = 1'b1;
        waited      = 0;
        while ((exp_q.size() != 0 || valid_out) && waited < 50) begin
            step();
            waited++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_idle", 32'(valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
